// File: rtl/vga_mixer_pkg.sv
// Shared game-state encodings and colour helpers for the VGA layer mixer.
// Optional fade-in on entry to play is enabled with MIXER_FADE_EN.
package vga_mixer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_WIN1 = 2'b10,
        ST_WIN2 = 2'b11
    } game_st_t;

    localparam int MAX_RGB_W = 48;

    // Per-channel logical right shift; bits never cross channel borders.
    function automatic logic [MAX_RGB_W-1:0] chan_shift(
        input logic [MAX_RGB_W-1:0] rgb,
        input int                   cw,
        input int                   lvl
    );
        logic [MAX_RGB_W-1:0] res;
        res = '0;
        for (int c = 0; c < 3; c++) begin
            for (int b = 0; b < MAX_RGB_W / 3; b++) begin
                if ((b < cw) && (b + lvl < cw)) begin
                    res[c*cw+b] = rgb[c*cw+b+lvl];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/vga_layer_mixer_timer.sv
// Generic clk_1ms tick divider with synchronous clear.
// o_step pulses on the tick that wraps the counter.
module mixer_tick_timer #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_tick,
    output logic o_step
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == CNT_W'(DIV - 1));
    assign o_step = i_tick & w_last & ~i_clr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_tick) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_layer_mixer.sv
// Priority layer compositor with game-mode display and 2-cycle latency.
// Define MIXER_FADE_EN to fade the picture in when play starts.
module vga_layer_mixer
    import vga_mixer_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int COLOR_W    = 12,
    parameter int FLASH_MS   = 250,
    parameter int FADE_MS    = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          video,
    input  logic                          clk_1ms,
    input  logic [NUM_LAYERS-1:0]         layer_on,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb,
    input  logic [COLOR_W-1:0]            bg_rgb,
    input  logic [1:0]                    stateGm,
    output logic [COLOR_W-1:0]            redgrnblu,
    output logic                          video_d
);

    game_st_t           w_st;
    logic               w_chg;
    logic               w_flash_clr;
    logic               w_flash_step;
    logic [COLOR_W-1:0] w_sel;
    logic [COLOR_W-1:0] w_play;
    logic [COLOR_W-1:0] w_s2;

    game_st_t           r_mode;
    logic               r_v1;
    logic [COLOR_W-1:0] r_sel;
    logic [COLOR_W-1:0] r_l0;
    logic [COLOR_W-1:0] r_l1;
    logic               r_phase;
    logic [COLOR_W-1:0] r_rgb;
    logic               r_vd;

    assign w_st = game_st_t'(stateGm);
    // r_mode holds last cycle's stateGm, so it doubles as the change reference.
    assign w_chg       = (w_st != r_mode);
    assign w_flash_clr = w_chg | ~stateGm[1];

    mixer_tick_timer #(
        .DIV    (FLASH_MS)
    ) u_flash (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_flash_clr),
        .i_tick (clk_1ms),
        .o_step (w_flash_step)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase <= 1'b1;
        end else if (w_flash_clr) begin
            r_phase <= 1'b1;
        end else if (w_flash_step) begin
            r_phase <= ~r_phase;
        end
    end

`ifdef MIXER_FADE_EN
    localparam int CW    = COLOR_W / 3;
    localparam int LVL_W = (CW > 1) ? $clog2(CW) : 1;

    logic             w_in_play;
    logic             w_fade_clr;
    logic             w_fade_step;
    logic [LVL_W-1:0] r_lvl;

    assign w_in_play  = (w_st == ST_PLAY);
    assign w_fade_clr = ~w_in_play | w_chg;

    mixer_tick_timer #(
        .DIV    (FADE_MS)
    ) u_fade (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_fade_clr),
        .i_tick (clk_1ms),
        .o_step (w_fade_step)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lvl <= '0;
        end else if (!w_in_play) begin
            r_lvl <= '0;
        end else if (w_chg) begin
            r_lvl <= LVL_W'(CW - 1);
        end else if (w_fade_step && (r_lvl != '0)) begin
            r_lvl <= r_lvl - 1'b1;
        end
    end

    assign w_play = COLOR_W'(chan_shift(MAX_RGB_W'(r_sel), CW, int'(r_lvl)));
`else
    assign w_play = r_sel;
`endif

    // Lowest index wins, so scan from the top and let lower hits overwrite.
    always_comb begin
        w_sel = bg_rgb;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_on[i]) begin
                w_sel = layer_rgb[i*COLOR_W +: COLOR_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode <= ST_IDLE;
            r_v1   <= 1'b0;
            r_sel  <= '0;
            r_l0   <= '0;
            r_l1   <= '0;
        end else begin
            r_mode <= w_st;
            r_v1   <= video;
            r_sel  <= w_sel;
            r_l0   <= layer_rgb[0 +: COLOR_W];
            r_l1   <= layer_rgb[COLOR_W +: COLOR_W];
        end
    end

    always_comb begin
        w_s2 = '0;
        unique case (r_mode)
            ST_IDLE: w_s2 = '0;
            ST_PLAY: w_s2 = w_play;
            ST_WIN1: w_s2 = r_phase ? r_l0 : '0;
            ST_WIN2: w_s2 = r_phase ? r_l1 : '0;
            default: w_s2 = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rgb <= '0;
            r_vd  <= 1'b0;
        end else begin
            r_rgb <= r_v1 ? w_s2 : '0;
            r_vd  <= r_v1;
        end
    end

    assign redgrnblu = r_rgb;
    assign video_d   = r_vd;

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Scoreboard bench for vga_layer_mixer: a cycle model queues expected
// pixels at drive time and they are compared two clocks later.
module tb_vga_layer_mixer;

    localparam int NL  = 4;
    localparam int CWD = 12;
    localparam int CH  = 4;
    localparam int FL  = 4;
    localparam int FD  = 2;

    logic            clk;
    logic            reset;
    logic            video;
    logic            clk_1ms;
    logic [NL-1:0]   layer_on;
    logic [NL*CWD-1:0] layer_rgb;
    logic [CWD-1:0]  bg_rgb;
    logic [1:0]      stateGm;
    logic [CWD-1:0]  redgrnblu;
    logic            video_d;

    vga_layer_mixer #(
        .NUM_LAYERS (NL),
        .COLOR_W    (CWD),
        .FLASH_MS   (FL),
        .FADE_MS    (FD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .video     (video),
        .clk_1ms   (clk_1ms),
        .layer_on  (layer_on),
        .layer_rgb (layer_rgb),
        .bg_rgb    (bg_rgb),
        .stateGm   (stateGm),
        .redgrnblu (redgrnblu),
        .video_d   (video_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [CWD-1:0] rgb;
        logic           vd;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   tc     = 0;

    int         m_cnt;
    int         m_fc;
    int         m_lvl;
    bit         m_ph;
    logic [1:0] m_prev;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [CWD-1:0] fshift(input logic [CWD-1:0] x,
                                              input int l);
        logic [CWD-1:0] r;
        logic [CWD-1:0] c;
        r = '0;
        for (int k = 0; k < 3; k++) begin
            c = (x >> (CH * k)) & 12'h00F;
            c = c >> l;
            r = r | (c << (CH * k));
        end
        return r;
    endfunction

    task automatic model_reset();
        m_cnt  = 0;
        m_fc   = 0;
        m_lvl  = 0;
        m_ph   = 1'b1;
        m_prev = 2'b00;
        q.delete();
    endtask

    task automatic cyc(input string tag, input logic [1:0] st,
                       input logic v, input logic [NL-1:0] on);
        exp_t       e;
        logic       tk;
        logic       chg;
        logic [CWD-1:0] sel;
        tk = ((tc % 10) == 9);
        tc++;
        stateGm  = st;
        video    = v;
        clk_1ms  = tk;
        layer_on = on;
        chg = (st != m_prev);
        if (!st[1] || chg) begin
            m_cnt = 0;
            m_ph  = 1'b1;
        end else if (tk) begin
            if (m_cnt == FL - 1) begin
                m_cnt = 0;
                m_ph  = ~m_ph;
            end else begin
                m_cnt++;
            end
        end
`ifdef MIXER_FADE_EN
        if (st != 2'b01) begin
            m_lvl = 0;
            m_fc  = 0;
        end else if (chg) begin
            m_lvl = CH - 1;
            m_fc  = 0;
        end else if (tk) begin
            if (m_fc == FD - 1) begin
                m_fc = 0;
                if (m_lvl > 0) m_lvl--;
            end else begin
                m_fc++;
            end
        end
`endif
        m_prev = st;
        sel = bg_rgb;
        for (int i = 0; i < NL; i++) begin
            if (on[i]) begin
                sel = layer_rgb[i*CWD +: CWD];
                break;
            end
        end
        case (st)
            2'b01:   e.rgb = fshift(sel, m_lvl);
            2'b10:   e.rgb = m_ph ? layer_rgb[11:0] : 12'h000;
            2'b11:   e.rgb = m_ph ? layer_rgb[23:12] : 12'h000;
            default: e.rgb = 12'h000;
        endcase
        if (!v) e.rgb = 12'h000;
        e.vd = v;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() >= 2) begin
            e = q.pop_front();
            chk({tag, "_rgb"}, 32'(redgrnblu), 32'(e.rgb));
            chk({tag, "_vd"}, 32'(video_d), 32'(e.vd));
        end
    endtask

    initial begin
        reset     = 1'b0;
        video     = 1'b0;
        clk_1ms   = 1'b0;
        layer_on  = '0;
        layer_rgb = {12'h00F, 12'h0F0, 12'hF00, 12'hABC};
        bg_rgb    = 12'h123;
        stateGm   = 2'b00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rgb", 32'(redgrnblu), 32'h0);
        chk("rst_vd", 32'(video_d), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        repeat (5) cyc("idle", 2'b00, 1'b1, 4'b1111);
        repeat (6) cyc("pri", 2'b01, 1'b1, 4'b0110);
        repeat (6) cyc("bg", 2'b01, 1'b1, 4'b0000);
        repeat (40) begin
            layer_rgb = {$urandom, $urandom};
            bg_rgb    = 12'($urandom);
            cyc("rnd", 2'b01, ($urandom_range(0, 7) != 0),
                4'($urandom_range(0, 15)));
        end
        layer_rgb = {12'h00F, 12'h0F0, 12'hF00, 12'hABC};
        bg_rgb    = 12'h123;
        repeat (4) cyc("vpul", 2'b01, 1'b1, 4'b0100);
        repeat (3) cyc("vpul", 2'b01, 1'b0, 4'b0100);
        repeat (4) cyc("vpul", 2'b01, 1'b1, 4'b0100);

        repeat (130) cyc("win1", 2'b10, 1'b1, 4'b0001);
        while ((tc % 10) != 9) cyc("win1", 2'b10, 1'b1, 4'b0001);
        cyc("chg", 2'b11, 1'b1, 4'b0010);
        repeat (60) cyc("win2", 2'b11, 1'b1, 4'b0010);

        repeat (3) cyc("pre", 2'b00, 1'b1, 4'b0000);
        repeat (15) cyc("flash", 2'b10, 1'b1, 4'b0001);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_rgb", 32'(redgrnblu), 32'h0);
        chk("arst_vd", 32'(video_d), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("hold_rgb", 32'(redgrnblu), 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (4) cyc("post", 2'b00, 1'b1, 4'b0001);
        repeat (20) cyc("postw", 2'b10, 1'b1, 4'b0001);

        repeat (3) cyc("fidle", 2'b00, 1'b1, 4'b0001);
        layer_rgb[11:0] = 12'hFFF;
        repeat (120) cyc("fade", 2'b01, 1'b1, 4'b0001);
        repeat (2) cyc("tail", 2'b00, 1'b0, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_layer_mixer.md
Name: vga_layer_mixer

Overview:
Parametrised pixel compositor for the VGA pong display path. It sits between the object generators (paddles, ball, score, …) and the VGA DAC pins. It selects the highest-priority active layer per pixel and applies a game-state display mode (blank, play, win-flash). Output is registered through a fixed 2-stage pipeline, with video-enable delayed to match.

Parameters:
NUM_LAYERS, 4, number of object layers; layer 0 has the highest priority; must be >= 2
COLOR_W, 12, pixel width; must be divisible by 3; CW = COLOR_W/3 bits per R/G/B channel
FLASH_MS, 250, clk_1ms ticks per half-period of the win flash; must be >= 1
FADE_MS, 64, clk_1ms ticks per fade step (used only with MIXER_FADE_EN)

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-low reset
video  in  1  active-video from the sync generator, aligned with layer inputs
clk_1ms  in  1  single-cycle 1 ms tick, synchronous to clk
layer_on  in  NUM_LAYERS  per-layer pixel-hit flags; bit i belongs to layer i
layer_rgb  in  NUM_LAYERS*COLOR_W  packed layer colours; layer i occupies [i*COLOR_W +: COLOR_W]
bg_rgb  in  COLOR_W  background colour when no layer is hit
stateGm  in  2  game state: 00 idle, 01 play, 10 player-1 win, 11 player-2 win
redgrnblu  out  COLOR_W  pixel to the DAC
video_d  out  1  video delayed by 2 cycles

Behaviour:
- Reset is asynchronous and active-low. While reset=0, redgrnblu=0, video_d=0, all pipeline registers=0, flash counter=0, flash phase=1, and the registered mode=idle.
- Stage 1, registered:
  - sel_rgb = layer_rgb of the lowest index i with layer_on[i]=1; if no bit is set, sel_rgb = bg_rgb.
  - Also registers mode_q = stateGm and v1 = video.
- Stage 2, registered output:
  - idle (00): 0.
  - play (01): sel_rgb.
  - win1 (10): layer 0 colour, registered in stage 1, when phase=1; otherwise 0.
  - win2 (11): layer 1 colour when phase=1; otherwise 0.
  - redgrnblu = stage-2 value if v2=1, else 0. This blanking is applied in the register, so redgrnblu is fully registered.
  - video_d = v2.
- Latency: 2 clk from the inputs to redgrnblu/video_d, for all modes.
- Flash timer, counting clk_1ms ticks:
  - Counter runs 0..FLASH_MS-1. On reaching FLASH_MS-1 with a tick, it wraps to 0 and phase toggles.
  - Counter and phase advance only in win1/win2. In all other states, counter=0 and phase=1.
- State change: detected when stateGm differs from the previous-cycle stateGm.
  - On change, counter clears to 0 and phase sets to 1 in the same cycle.
  - A change coincident with a clk_1ms tick takes priority; the tick is discarded.
- Undefined states: none; all four codes are decoded.
- Reset mid-frame: output drops to 0 immediately. Normal behaviour resumes 2 cycles after the reset release edge.

Optional Feature:
MIXER_FADE_EN
- Defined: on entry to play from any other state, fade level L is set to CW-1.
  - L decrements by 1 every FADE_MS clk_1ms ticks until it reaches 0.
  - In play, each R/G/B channel of the stage-2 value is logically right-shifted by L; there is no carry between channels.
  - Leaving play sets L=0. Reset sets L=0.
- Undefined: no fade logic; play output is sel_rgb unchanged. Latency is identical in both builds.

Decomposition:
- Package vga_mixer_pkg holds:
  - the stateGm encodings ST_IDLE, ST_PLAY, ST_WIN1, ST_WIN2;
  - the function chan_shift(rgb, L), which shifts each channel right by L.
- One natural sub-module: mixer_tick_timer, a generic clk_1ms-tick divider with synchronous clear. It produces the phase toggle and, when MIXER_FADE_EN is defined, the fade step.

Test Plan:
- NUM_LAYERS=4, play, layer_on=4'b0110, layer1=12'hF00, layer2=12'h0F0, video=1 -> redgrnblu=12'hF00 exactly 2 clk later; layer_on=0 with bg_rgb=12'h123 -> 12'h123.
- Play, then video pulsed 0 for 3 cycles -> redgrnblu=0 and video_d=0 for exactly those 3 cycles, delayed by 2.
- Win1, FLASH_MS=4, layer0=12'hABC, clk_1ms every 10 clk -> output toggles between 12'hABC and 0 every 4 ticks, starting with 12'hABC.
- Win1 to win2 change on the same cycle as a tick -> phase=1 and counter=0; first toggle occurs after 4 further ticks, showing the layer-1 colour.
- reset=0 asserted mid-flash (asynchronous, between clk edges) -> redgrnblu=0 and video_d=0 immediately; after release, phase=1 and idle output=0.
- MIXER_FADE_EN build, CW=4, FADE_MS=2, idle to play with sel=12'hFFF -> 12'h111, 12'h333, 12'h777, 12'hFFF, each held 2 ticks.
